// File: rtl/nasti_rd_sched.sv
// Read-side scheduler for a NASTI N-to-1 interconnect: round-robin AR arbitration
// with per-port credits and ID-conflict stalls, plus an ID table that routes R beats home.
module nasti_rd_sched #(
    parameter int unsigned N_PORT      = 4,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned R_MAX       = 4,
    parameter int unsigned PORT_CREDIT = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_PORT-1:0]             s_ar_valid,
    input  logic [N_PORT*ID_WIDTH-1:0]    s_ar_id,
    output logic [N_PORT-1:0]             s_ar_ready,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    output logic [$clog2(N_PORT)-1:0]     ar_sel,
    input  logic                          m_r_valid,
    input  logic [ID_WIDTH-1:0]           m_r_id,
    input  logic                          m_r_last,
    output logic                          m_r_ready,
    output logic [N_PORT-1:0]             s_r_valid,
    input  logic [N_PORT-1:0]             s_r_ready,
    output logic [$clog2(N_PORT)-1:0]     r_route,
    output logic [$clog2(R_MAX):0]        outstanding,
    output logic                          err_unmatched
);

    localparam int unsigned SEL_W = $clog2(N_PORT);
    localparam int unsigned IDX_W = $clog2(R_MAX);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned CRD_W = $clog2(PORT_CREDIT + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [SEL_W-1:0]    port;
    } entry_t;

    typedef enum logic [0:0] {ST_ARB, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [R_MAX-1:0]   tbl_valid;
    entry_t             tbl [R_MAX];
    logic [CRD_W-1:0]   credit [N_PORT];
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   hold_port;
    logic               run;

    logic [N_PORT-1:0]  eligible;
    logic               win_found;
    logic [SEL_W-1:0]   winner;
    logic               tbl_full;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               match_found;
    logic [IDX_W-1:0]   match_idx;
    logic               ar_fire;
    logic               r_release;
    logic [ID_WIDTH-1:0] ar_id_sel;

    assign tbl_full  = &tbl_valid;
    assign ar_fire   = m_ar_valid & m_ar_ready;
    assign r_release = m_r_valid & m_r_ready & m_r_last & match_found;
    assign ar_id_sel = s_ar_id[ar_sel*ID_WIDTH +: ID_WIDTH];

    // Eligibility and round-robin search upward from rr_ptr
    always_comb begin : p_arb
        logic        conflict;
        int unsigned cand;
        conflict  = 1'b0;
        cand      = 0;
        eligible  = '0;
        win_found = 1'b0;
        winner    = '0;
        for (int p = 0; p < int'(N_PORT); p++) begin
            conflict = 1'b0;
            for (int e = 0; e < int'(R_MAX); e++) begin
                if (tbl_valid[e] && tbl[e].id == s_ar_id[p*ID_WIDTH +: ID_WIDTH] &&
                    tbl[e].port != SEL_W'(p))
                    conflict = 1'b1;
            end
            eligible[p] = s_ar_valid[p] && (credit[p] < CRD_W'(PORT_CREDIT)) &&
                          !tbl_full && !conflict;
        end
        for (int k = 0; k < int'(N_PORT); k++) begin
            cand = (int'(rr_ptr) + k) % N_PORT;
            if (!win_found && eligible[SEL_W'(cand)]) begin
                win_found = 1'b1;
                winner    = SEL_W'(cand);
            end
        end
    end

    // Lowest free slot (registered state only, so a same-cycle release is not reused)
    always_comb begin : p_alloc
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = 0; e < int'(R_MAX); e++) begin
            if (!free_found && !tbl_valid[e]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(e);
            end
        end
    end

    // AR issue FSM: hold keeps a stalled request stable until accepted
    always_comb begin : p_fsm
        state_d    = state_q;
        m_ar_valid = 1'b0;
        ar_sel     = '0;
        s_ar_ready = '0;
        if (run) begin
            case (state_q)
                ST_ARB: begin
                    ar_sel     = winner;
                    m_ar_valid = win_found;
                    if (win_found && !m_ar_ready)
                        state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    ar_sel     = hold_port;
                    m_ar_valid = 1'b1;
                    if (m_ar_ready)
                        state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            s_ar_ready[ar_sel] = m_ar_valid & m_ar_ready;
        end
    end

    // R routing: lowest-index valid entry with the beat's id; unmatched beats are sunk
    always_comb begin : p_route
        match_found   = 1'b0;
        match_idx     = '0;
        r_route       = '0;
        s_r_valid     = '0;
        m_r_ready     = 1'b0;
        err_unmatched = 1'b0;
        for (int e = 0; e < int'(R_MAX); e++) begin
            if (!match_found && tbl_valid[e] && tbl[e].id == m_r_id) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(e);
            end
        end
        if (match_found)
            r_route = tbl[match_idx].port;
        if (run) begin
            if (match_found) begin
                s_r_valid[r_route] = m_r_valid;
                m_r_ready          = s_r_ready[r_route];
            end else begin
                m_r_ready     = m_r_valid;
                err_unmatched = m_r_valid;
            end
        end
    end

    always_comb begin : p_count
        outstanding = '0;
        for (int e = 0; e < int'(R_MAX); e++)
            outstanding = outstanding + CNT_W'(tbl_valid[e]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_ARB;
            hold_port <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ARB && m_ar_valid && !m_ar_ready)
                hold_port <= ar_sel;
        end
    end

    // Table, credits and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run       <= 1'b0;
            tbl_valid <= '0;
            rr_ptr    <= '0;
            for (int e = 0; e < int'(R_MAX); e++)
                tbl[e] <= '0;
            for (int p = 0; p < int'(N_PORT); p++)
                credit[p] <= '0;
        end else begin
            run <= 1'b1;
            if (r_release)
                tbl_valid[match_idx] <= 1'b0;
            if (ar_fire && free_found) begin
                tbl_valid[free_idx] <= 1'b1;
                tbl[free_idx]       <= '{id: ar_id_sel, port: ar_sel};
                rr_ptr              <= (ar_sel == SEL_W'(N_PORT - 1)) ? '0 : ar_sel + 1'b1;
            end
            for (int p = 0; p < int'(N_PORT); p++) begin
                credit[p] <= credit[p]
                           + CRD_W'(ar_fire && ar_sel == SEL_W'(p))
                           - CRD_W'(r_release && tbl[match_idx].port == SEL_W'(p));
            end
        end
    end

endmodule

// File: tb/tb_nasti_rd_sched.sv
// Bench for nasti_rd_sched: directed scenarios plus randomized traffic against a
// slot-array reference model that derives credits and occupancy by counting entries.
module tb_nasti_rd_sched;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int RM = 4;
    localparam int PC = 2;

    logic            clk;
    logic            rstn;
    logic [NP-1:0]   s_ar_valid;
    logic [NP*IW-1:0] s_ar_id;
    logic [NP-1:0]   s_ar_ready;
    logic            m_ar_valid;
    logic            m_ar_ready;
    logic [1:0]      ar_sel;
    logic            m_r_valid;
    logic [IW-1:0]   m_r_id;
    logic            m_r_last;
    logic            m_r_ready;
    logic [NP-1:0]   s_r_valid;
    logic [NP-1:0]   s_r_ready;
    logic [1:0]      r_route;
    logic [2:0]      outstanding;
    logic            err_unmatched;

    nasti_rd_sched #(.N_PORT(NP), .ID_WIDTH(IW), .R_MAX(RM), .PORT_CREDIT(PC)) dut (
        .clk(clk), .rstn(rstn),
        .s_ar_valid(s_ar_valid), .s_ar_id(s_ar_id), .s_ar_ready(s_ar_ready),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .ar_sel(ar_sel),
        .m_r_valid(m_r_valid), .m_r_id(m_r_id), .m_r_last(m_r_last), .m_r_ready(m_r_ready),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .r_route(r_route),
        .outstanding(outstanding), .err_unmatched(err_unmatched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot array of outstanding reads
    bit mv [RM];
    int mid [RM];
    int mport [RM];
    int m_rr;
    bit m_hold;
    int m_hold_port;
    bit e_fire;
    int e_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < RM; e++) begin
            mv[e] = 0; mid[e] = 0; mport[e] = 0;
        end
        m_rr = 0; m_hold = 0; m_hold_port = 0;
    endtask

    // Compare current-cycle outputs with the model, then advance the model
    task automatic model_step();
        int cnt; int pc [NP]; bit elig [NP]; bit conflict; bit vld; int sel; int q;
        bit mf; int midx; int route; bit exp_mrr; bit rel; int fslot;
        logic [NP-1:0] exp_srv; logic [NP-1:0] exp_srar;
        cnt = 0; midx = 0; route = 0; fslot = -1;
        for (int p = 0; p < NP; p++) pc[p] = 0;
        for (int e = 0; e < RM; e++)
            if (mv[e]) begin cnt++; pc[mport[e]]++; end
        for (int p = 0; p < NP; p++) begin
            conflict = 0;
            for (int e = 0; e < RM; e++)
                if (mv[e] && mid[e] == int'(s_ar_id[p*IW +: IW]) && mport[e] != p) conflict = 1;
            elig[p] = s_ar_valid[p] && pc[p] < PC && cnt < RM && !conflict;
        end
        vld = 0; sel = 0;
        if (m_hold) begin
            vld = 1; sel = m_hold_port;
        end else begin
            for (int k = 0; k < NP; k++) begin
                q = (m_rr + k) % NP;
                if (!vld && elig[q]) begin vld = 1; sel = q; end
            end
        end
        exp_srar = (vld && m_ar_ready) ? (NP'(1) << sel) : '0;
        check_eq("m_ar_valid", 32'(m_ar_valid), 32'(vld));
        if (vld) check_eq("ar_sel", 32'(ar_sel), 32'(sel));
        check_eq("s_ar_ready", 32'(s_ar_ready), 32'(exp_srar));
        check_eq("outstanding", 32'(outstanding), 32'(cnt));

        mf = 0;
        for (int e = 0; e < RM; e++)
            if (!mf && mv[e] && mid[e] == int'(m_r_id)) begin mf = 1; midx = e; end
        if (mf) begin
            route   = mport[midx];
            exp_srv = m_r_valid ? (NP'(1) << route) : '0;
            exp_mrr = s_r_ready[route];
            check_eq("r_route", 32'(r_route), 32'(route));
        end else begin
            exp_srv = '0;
            exp_mrr = m_r_valid;
        end
        check_eq("s_r_valid", 32'(s_r_valid), 32'(exp_srv));
        if (mf || m_r_valid) check_eq("m_r_ready", 32'(m_r_ready), 32'(exp_mrr));
        check_eq("err_unmatched", 32'(err_unmatched), 32'(m_r_valid && !mf));

        for (int e = RM - 1; e >= 0; e--)
            if (!mv[e]) fslot = e;
        rel    = m_r_valid && exp_mrr && m_r_last && mf;
        e_fire = vld && m_ar_ready;
        e_sel  = sel;
        if (rel) mv[midx] = 0;
        if (e_fire) begin
            if (fslot < 0) check_eq("alloc_slot", 32'(fslot), 32'(0));
            else begin
                mv[fslot] = 1; mid[fslot] = int'(s_ar_id[sel*IW +: IW]); mport[fslot] = sel;
            end
            m_rr = (sel + 1) % NP;
            m_hold = 0;
        end else if (vld) begin
            m_hold = 1; m_hold_port = sel;
        end
    endtask

    task automatic cycle(input logic [NP-1:0] av, input logic [NP*IW-1:0] aid, input logic ardy,
                         input logic rv, input logic [IW-1:0] rid, input logic rl,
                         input logic [NP-1:0] srr);
        @(negedge clk);
        s_ar_valid = av; s_ar_id = aid; m_ar_ready = ardy;
        m_r_valid = rv; m_r_id = rid; m_r_last = rl; s_r_ready = srr;
        #1;
        model_step();
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_m_ar_valid"}, 32'(m_ar_valid), 32'(0));
        check_eq({tag, "_s_ar_ready"}, 32'(s_ar_ready), 32'(0));
        check_eq({tag, "_s_r_valid"}, 32'(s_r_valid), 32'(0));
        check_eq({tag, "_outstanding"}, 32'(outstanding), 32'(0));
        check_eq({tag, "_err"}, 32'(err_unmatched), 32'(0));
        check_eq({tag, "_ar_sel"}, 32'(ar_sel), 32'(0));
        if (!m_r_valid) check_eq({tag, "_m_r_ready"}, 32'(m_r_ready), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        reset_checks("rst_low");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        reset_checks("rst_first");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NP-1:0]    pend;
        logic [NP*IW-1:0] pid;
        logic [IW-1:0]    rid;
        int k;
        rstn = 1'b1;
        s_ar_valid = '1; s_ar_id = 8'h1B; m_ar_ready = 1'b1;
        m_r_valid = 1'b0; m_r_id = '0; m_r_last = 1'b0; s_r_ready = '1;
        do_reset();

        // Round-robin 0,2,0 then 2 (port 0 out of credit), table fills
        cycle(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("rr_g0", 32'(ar_sel), 32'(0));
        cycle(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("rr_g2", 32'(ar_sel), 32'(2));
        check_eq("rr_out1", 32'(outstanding), 32'(1));
        cycle(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("rr_wrap0", 32'(ar_sel), 32'(0));
        cycle(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("rr_credit_g2", 32'(ar_sel), 32'(2));
        check_eq("rr_out3", 32'(outstanding), 32'(3));
        cycle(4'b0101, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("full_out", 32'(outstanding), 32'(4));
        check_eq("full_stall", 32'(m_ar_valid), 32'(0));
        cycle(4'b0000, 8'h00, 1, 1, 2'd0, 1, 4'b1111);
        check_eq("r_route_p0", 32'(s_r_valid), 32'(4'b0001));
        cycle(4'b0000, 8'h00, 1, 1, 2'd1, 1, 4'b1111);
        cycle(4'b0000, 8'h00, 1, 1, 2'd0, 1, 4'b1111);
        cycle(4'b0000, 8'h00, 1, 1, 2'd1, 1, 4'b1111);
        cycle(4'b0000, 8'h00, 1, 0, 2'd0, 0, 4'b1111);
        check_eq("drain_out", 32'(outstanding), 32'(0));

        // Hold: port 1 granted under backpressure while port 3 also requests
        cycle(4'b1000, {2'd3, 2'd0, 2'd2, 2'd0}, 1, 0, 0, 0, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, {2'd3, 2'd0, 2'd2, 2'd0}, 0, 0, 0, 0, 4'b1111);
            check_eq("hold_sel", 32'(ar_sel), 32'(1));
            check_eq("hold_valid", 32'(m_ar_valid), 32'(1));
        end
        cycle(4'b1010, {2'd3, 2'd0, 2'd2, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("hold_accept", 32'(s_ar_ready), 32'(4'b0010));
        cycle(4'b1000, {2'd3, 2'd0, 2'd2, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("hold_next_p3", 32'(ar_sel), 32'(3));
        cycle(4'b0000, 8'h00, 1, 1, 2'd3, 1, 4'b1111);
        cycle(4'b0000, 8'h00, 1, 1, 2'd3, 1, 4'b1111);
        cycle(4'b0000, 8'h00, 1, 1, 2'd2, 1, 4'b1111);

        // Credit stall on port 0, released by a last beat
        cycle(4'b0001, 8'h01, 1, 0, 0, 0, 4'b0001);
        cycle(4'b0001, 8'h01, 1, 0, 0, 0, 4'b0001);
        cycle(4'b0001, 8'h01, 1, 0, 0, 0, 4'b0001);
        check_eq("credit_stall", 32'(m_ar_valid), 32'(0));
        cycle(4'b0001, 8'h01, 1, 1, 2'd1, 1, 4'b0001);
        check_eq("credit_route", 32'(s_r_valid), 32'(4'b0001));
        check_eq("credit_still", 32'(m_ar_valid), 32'(0));
        cycle(4'b0001, 8'h01, 1, 0, 0, 0, 4'b0001);
        check_eq("credit_issue", 32'(m_ar_valid), 32'(1));

        // ID conflict: port 2 id 1 waits for port 0's id-1 entries
        cycle(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("conflict_stall", 32'(m_ar_valid), 32'(0));
        cycle(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 1, 2'd1, 1, 4'b1111);
        cycle(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 1, 2'd1, 1, 4'b1111);
        check_eq("conflict_stall2", 32'(m_ar_valid), 32'(0));
        cycle(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 1, 0, 0, 0, 4'b1111);
        check_eq("conflict_grant", 32'(ar_sel), 32'(2));
        check_eq("conflict_grant_v", 32'(m_ar_valid), 32'(1));

        // Unmatched beat is sunk with a one-cycle error pulse
        cycle(4'b0000, 8'h00, 1, 1, 2'd3, 1, 4'b0000);
        check_eq("unm_ready", 32'(m_r_ready), 32'(1));
        check_eq("unm_err", 32'(err_unmatched), 32'(1));
        cycle(4'b0000, 8'h00, 1, 0, 2'd3, 0, 4'b0000);
        check_eq("unm_err_clr", 32'(err_unmatched), 32'(0));
        check_eq("unm_out", 32'(outstanding), 32'(1));

        // Reset mid-operation with three entries and a burst in flight
        cycle(4'b1011, {2'd3, 2'd0, 2'd2, 2'd0}, 1, 0, 0, 0, 4'b1111);
        cycle(4'b0011, {2'd3, 2'd0, 2'd2, 2'd0}, 1, 0, 0, 0, 4'b1111);
        cycle(4'b0010, {2'd3, 2'd0, 2'd2, 2'd0}, 0, 1, 2'd1, 0, 4'b0100);
        check_eq("mid_out3", 32'(outstanding), 32'(3));
        do_reset();
        cycle(4'b0000, 8'h00, 1, 1, 2'd1, 1, 4'b1111);
        check_eq("post_rst_err", 32'(err_unmatched), 32'(1));

        // Randomized traffic with sticky AR requests
        pend = '0; pid = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++)
                if (!pend[p] && $urandom_range(2, 0) == 0) begin
                    pend[p] = 1'b1;
                    pid[p*IW +: IW] = IW'($urandom_range(3, 0));
                end
            rid = IW'($urandom_range(3, 0));
            if ($urandom_range(4, 0) != 0) begin
                k = int'($urandom_range(RM - 1, 0));
                if (mv[k]) rid = IW'(mid[k]);
            end
            cycle(pend, pid, 1'($urandom_range(2, 0) != 0), 1'($urandom_range(1, 0)), rid,
                  1'($urandom_range(1, 0)), NP'($urandom_range(15, 0)));
            if (e_fire) pend[e_sel] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
